// File: rtl/sd_wb_master_arb_pkg.sv
// Shared SD controller constants: buffer memory offset, Wishbone requester
// indices and the master arbiter state encoding.
package sd_wb_master_arb_pkg;

    // Base of the data buffer window in the Wishbone address space.
    localparam logic [31:0] MEM_OFFSET = 32'h0000_0000;

    // Requester indices (also the encoding of the last-granted register).
    localparam logic REQ_TX = 1'b0;
    localparam logic REQ_RX = 1'b1;

    // Width of the stall watchdog counter.
    localparam int unsigned STALL_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GNT_TX = 2'd1,
        ARB_GNT_RX = 2'd2,
        ARB_ABORT  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/sd_wb_master_arb.sv
// Two-requester Wishbone master arbiter for the SD controller.
// The TX filler (reads) and the RX filler (writes) share one Wishbone master
// port. Arbitration is round-robin on ties, every release goes through IDLE,
// and a stalled grant is aborted with an error pulse after TIMEOUT cycles.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   tx_*                   requester 0 (TX filler): adr/we/cyc/stb/cti/bte in,
//                          dat/ack/err out
//   rx_*                   requester 1 (RX filler): adr/we/dat/cyc/stb/cti/bte
//                          in, ack/err out
//   m_wb_*                 shared Wishbone master port
//   grant_o                {RX, TX} one-hot grant, zero when idle/aborting
//   busy_o                 arbiter not idle
module sd_wb_master_arb
    import sd_wb_master_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] tx_adr_i,
    input  logic        tx_we_i,
    input  logic        tx_cyc_i,
    input  logic        tx_stb_i,
    input  logic [2:0]  tx_cti_i,
    input  logic [1:0]  tx_bte_i,
    output logic [31:0] tx_dat_o,
    output logic        tx_ack_o,
    output logic        tx_err_o,

    input  logic [31:0] rx_adr_i,
    input  logic        rx_we_i,
    input  logic [31:0] rx_dat_i,
    input  logic        rx_cyc_i,
    input  logic        rx_stb_i,
    input  logic [2:0]  rx_cti_i,
    input  logic [1:0]  rx_bte_i,
    output logic        rx_ack_o,
    output logic        rx_err_o,

    output logic [31:0] m_wb_adr_o,
    output logic        m_wb_we_o,
    output logic [31:0] m_wb_dat_o,
    input  logic [31:0] m_wb_dat_i,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    output logic [2:0]  m_wb_cti_o,
    output logic [1:0]  m_wb_bte_o,

    output logic [1:0]  grant_o,
    output logic        busy_o
);

    // Error is raised when the stall count is about to reach TIMEOUT-1.
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT - 2);
    localparam logic [STALL_W-1:0] STALL_MAX   = '1;

    arb_state_e         state_q, state_d;
    logic               last_gnt_q, last_gnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               tx_err_q, tx_err_d;
    logic               rx_err_q, rx_err_d;

    logic gnt_tx;
    logic gnt_rx;
    logic gnt_idx;
    logic gnt_cyc;
    logic gnt_stb;
    logic abort_cyc;

    assign gnt_tx  = (state_q == ARB_GNT_TX);
    assign gnt_rx  = (state_q == ARB_GNT_RX);
    assign gnt_idx = gnt_rx ? REQ_RX : REQ_TX;
    assign gnt_cyc = gnt_rx ? rx_cyc_i : tx_cyc_i;
    assign gnt_stb = gnt_rx ? rx_stb_i : tx_stb_i;

    // last_gnt is updated on ABORT entry, so it also names the aborted owner.
    assign abort_cyc = (last_gnt_q == REQ_RX) ? rx_cyc_i : tx_cyc_i;

    // State, arbitration history, stall watchdog and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= REQ_TX;
            stall_q    <= '0;
            tx_err_q   <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            stall_q    <= stall_d;
            tx_err_q   <= tx_err_d;
            rx_err_q   <= rx_err_d;
        end
    end

    // Next-state: arbitration, release, watchdog and abort handling.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        stall_d    = stall_q;
        tx_err_d   = 1'b0;
        rx_err_d   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                stall_d = '0;
                if (tx_cyc_i && rx_cyc_i) begin
                    // Tie goes to whoever was not served last.
                    state_d = (last_gnt_q == REQ_TX) ? ARB_GNT_RX : ARB_GNT_TX;
                end else if (tx_cyc_i) begin
                    state_d = ARB_GNT_TX;
                end else if (rx_cyc_i) begin
                    state_d = ARB_GNT_RX;
                end
            end

            ARB_GNT_TX, ARB_GNT_RX: begin
                if (m_wb_ack_i) begin
                    stall_d = '0;
                end else if (gnt_stb && (stall_q != STALL_MAX)) begin
                    stall_d = stall_q + STALL_W'(1);
                end

                if (gnt_cyc && gnt_stb && !m_wb_ack_i && (stall_q == STALL_LIMIT)) begin
                    if (gnt_idx == REQ_RX) begin
                        rx_err_d = 1'b1;
                    end else begin
                        tx_err_d = 1'b1;
                    end
                end

                // A requester release wins over a pending abort.
                if (!gnt_cyc) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = gnt_idx;
                end else if (tx_err_q || rx_err_q) begin
                    state_d    = ARB_ABORT;
                    last_gnt_d = gnt_idx;
                end
            end

            ARB_ABORT: begin
                stall_d = '0;
                if (!abort_cyc) begin
                    state_d = ARB_IDLE;
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Master port and ack steering follow the granted requester combinationally.
    always_comb begin
        m_wb_adr_o = '0;
        m_wb_we_o  = 1'b0;
        m_wb_dat_o = '0;
        m_wb_cyc_o = 1'b0;
        m_wb_stb_o = 1'b0;
        m_wb_cti_o = '0;
        m_wb_bte_o = '0;
        tx_ack_o   = 1'b0;
        rx_ack_o   = 1'b0;

        if (gnt_tx) begin
            m_wb_adr_o = tx_adr_i;
            m_wb_we_o  = tx_we_i;
            m_wb_cyc_o = tx_cyc_i;
            m_wb_stb_o = tx_stb_i;
            m_wb_cti_o = tx_cti_i;
            m_wb_bte_o = tx_bte_i;
            tx_ack_o   = m_wb_ack_i;
        end else if (gnt_rx) begin
            m_wb_adr_o = rx_adr_i;
            m_wb_we_o  = rx_we_i;
            m_wb_dat_o = rx_dat_i;
            m_wb_cyc_o = rx_cyc_i;
            m_wb_stb_o = rx_stb_i;
            m_wb_cti_o = rx_cti_i;
            m_wb_bte_o = rx_bte_i;
            rx_ack_o   = m_wb_ack_i;
        end
    end

    assign tx_dat_o = m_wb_dat_i;
    assign tx_err_o = tx_err_q;
    assign rx_err_o = rx_err_q;
    assign grant_o  = {gnt_rx, gnt_tx};
    assign busy_o   = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_sd_wb_master_arb.sv
// Bench for sd_wb_master_arb: directed scenarios with literal expectations,
// plus a transaction-level arbiter model compared against the DUT every cycle.
module tb_sd_wb_master_arb;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] tx_adr_i = '0;
    logic        tx_we_i  = 1'b0;
    logic        tx_cyc_i = 1'b0;
    logic        tx_stb_i = 1'b0;
    logic [2:0]  tx_cti_i = '0;
    logic [1:0]  tx_bte_i = '0;
    logic [31:0] tx_dat_o;
    logic        tx_ack_o;
    logic        tx_err_o;

    logic [31:0] rx_adr_i = '0;
    logic        rx_we_i  = 1'b0;
    logic [31:0] rx_dat_i = '0;
    logic        rx_cyc_i = 1'b0;
    logic        rx_stb_i = 1'b0;
    logic [2:0]  rx_cti_i = '0;
    logic [1:0]  rx_bte_i = '0;
    logic        rx_ack_o;
    logic        rx_err_o;

    logic [31:0] m_wb_adr_o;
    logic        m_wb_we_o;
    logic [31:0] m_wb_dat_o;
    logic [31:0] m_wb_dat_i = '0;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        m_wb_ack_i = 1'b0;
    logic [2:0]  m_wb_cti_o;
    logic [1:0]  m_wb_bte_o;
    logic [1:0]  grant_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    sd_wb_master_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .tx_adr_i(tx_adr_i), .tx_we_i(tx_we_i), .tx_cyc_i(tx_cyc_i),
        .tx_stb_i(tx_stb_i), .tx_cti_i(tx_cti_i), .tx_bte_i(tx_bte_i),
        .tx_dat_o(tx_dat_o), .tx_ack_o(tx_ack_o), .tx_err_o(tx_err_o),
        .rx_adr_i(rx_adr_i), .rx_we_i(rx_we_i), .rx_dat_i(rx_dat_i),
        .rx_cyc_i(rx_cyc_i), .rx_stb_i(rx_stb_i), .rx_cti_i(rx_cti_i),
        .rx_bte_i(rx_bte_i), .rx_ack_o(rx_ack_o), .rx_err_o(rx_err_o),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_we_o(m_wb_we_o), .m_wb_dat_o(m_wb_dat_o),
        .m_wb_dat_i(m_wb_dat_i), .m_wb_cyc_o(m_wb_cyc_o), .m_wb_stb_o(m_wb_stb_o),
        .m_wb_ack_i(m_wb_ack_i), .m_wb_cti_o(m_wb_cti_o), .m_wb_bte_o(m_wb_bte_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 none, 1 TX, 2 RX, 3 aborting. last/who: 0 TX, 1 RX.
    int owner = 0;
    int last  = 0;
    int who   = 0;
    int stall = 0;
    bit e_tx  = 1'b0;
    bit e_rx  = 1'b0;

    always @(posedge clk or posedge rst) begin
        int idx;
        bit c, s, pend_tx, pend_rx, pend;
        if (rst) begin
            owner = 0; last = 0; who = 0; stall = 0; e_tx = 1'b0; e_rx = 1'b0;
        end else begin
            pend_tx = e_tx;
            pend_rx = e_rx;
            e_tx = 1'b0;
            e_rx = 1'b0;
            case (owner)
                0: begin
                    stall = 0;
                    if (tx_cyc_i && rx_cyc_i) owner = (last == 0) ? 2 : 1;
                    else if (tx_cyc_i)        owner = 1;
                    else if (rx_cyc_i)        owner = 2;
                end
                1, 2: begin
                    idx  = owner - 1;
                    c    = (idx == 1) ? rx_cyc_i : tx_cyc_i;
                    s    = (idx == 1) ? rx_stb_i : tx_stb_i;
                    pend = (idx == 1) ? pend_rx : pend_tx;
                    if (m_wb_ack_i) stall = 0;
                    else if (s)     stall = (stall < 255) ? stall + 1 : 255;
                    if (c && s && !m_wb_ack_i && stall == int'(TIMEOUT) - 1) begin
                        if (idx == 1) e_rx = 1'b1; else e_tx = 1'b1;
                    end
                    if (!c) begin
                        owner = 0; last = idx;
                    end else if (pend) begin
                        owner = 3; who = idx; last = idx;
                    end
                end
                default: begin
                    stall = 0;
                    if (!((who == 1) ? rx_cyc_i : tx_cyc_i)) owner = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [71:0] eb;
        logic [1:0]  eg;
        logic        ta, ra, te, re, ebusy;
        eb = '0; eg = '0; ta = 1'b0; ra = 1'b0; te = 1'b0; re = 1'b0; ebusy = 1'b0;
        if (!rst) begin
            if (owner == 1) begin
                eb = {tx_adr_i, tx_we_i, 32'h0, tx_cyc_i, tx_stb_i, tx_cti_i, tx_bte_i};
                ta = m_wb_ack_i;
                eg = 2'b01;
            end else if (owner == 2) begin
                eb = {rx_adr_i, rx_we_i, rx_dat_i, rx_cyc_i, rx_stb_i, rx_cti_i, rx_bte_i};
                ra = m_wb_ack_i;
                eg = 2'b10;
            end
            te = e_tx;
            re = e_rx;
            ebusy = (owner != 0);
        end
        chk("model_bus", {m_wb_adr_o, m_wb_we_o, m_wb_dat_o, m_wb_cyc_o, m_wb_stb_o,
                          m_wb_cti_o, m_wb_bte_o}, eb);
        chk("model_acks", 72'({tx_ack_o, rx_ack_o}), 72'({ta, ra}));
        chk("model_errs", 72'({tx_err_o, rx_err_o}), 72'({te, re}));
        chk("model_grant_busy", 72'({grant_o, busy_o}), 72'({eg, ebusy}));
        chk("model_tx_dat", 72'(tx_dat_o), 72'(m_wb_dat_i));
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tx_req(input logic on);
        tx_cyc_i = on;
        tx_stb_i = on;
    endtask

    task automatic rx_req(input logic on);
        rx_cyc_i = on;
        rx_stb_i = on;
    endtask

    initial begin
        tx_adr_i = 32'h1000_0040; tx_cti_i = 3'b010; tx_bte_i = 2'b00; tx_we_i = 1'b0;
        rx_adr_i = 32'h2000_0080; rx_cti_i = 3'b111; rx_bte_i = 2'b01; rx_we_i = 1'b1;
        rx_dat_i = 32'h1234_5678;

        // Reset state.
        reset_dut();
        mid();
        chk("rst_busy", 72'(busy_o), 72'(0));
        chk("rst_grant", 72'(grant_o), 72'(0));

        // TX-only transfer, ack at cycle 3.
        next_cycle(); tx_req(1'b1);                               // cycle 0
        mid(); chk("tx_c0_cyc", 72'(m_wb_cyc_o), 72'(0));
        next_cycle();                                             // cycle 1
        mid(); chk("tx_c1_cyc", 72'(m_wb_cyc_o), 72'(1));
        chk("tx_c1_grant", 72'(grant_o), 72'(2'b01));
        chk("tx_c1_adr", 72'(m_wb_adr_o), 72'(32'h1000_0040));
        next_cycle();                                             // cycle 2
        next_cycle(); m_wb_ack_i = 1'b1; m_wb_dat_i = 32'hA5A5_0001; // cycle 3
        mid(); chk("tx_c3_ack", 72'(tx_ack_o), 72'(1));
        chk("tx_c3_dat", 72'(tx_dat_o), 72'(32'hA5A5_0001));
        chk("tx_c3_cyc", 72'(m_wb_cyc_o), 72'(1));
        next_cycle(); m_wb_ack_i = 1'b0; tx_req(1'b0);            // cycle 4
        mid(); chk("tx_c4_cyc", 72'(m_wb_cyc_o), 72'(0));
        next_cycle();                                             // cycle 5
        mid(); chk("tx_c5_idle", 72'(busy_o), 72'(0));

        // Simultaneous requests after reset: RX, then TX, then RX again.
        reset_dut();
        next_cycle(); tx_req(1'b1); rx_req(1'b1);                 // cycle 0
        next_cycle(); m_wb_ack_i = 1'b1;                          // cycle 1
        mid(); chk("tie1_grant", 72'(grant_o), 72'(2'b10));
        chk("tie1_we", 72'(m_wb_we_o), 72'(1));
        chk("tie1_dat", 72'(m_wb_dat_o), 72'(32'h1234_5678));
        chk("tie1_txack", 72'(tx_ack_o), 72'(0));
        next_cycle(); m_wb_ack_i = 1'b0; rx_req(1'b0);            // cycle 2
        next_cycle();                                             // cycle 3
        mid(); chk("tie_turnaround", 72'(busy_o), 72'(0));
        next_cycle(); m_wb_ack_i = 1'b1;                          // cycle 4
        mid(); chk("tie2_grant", 72'(grant_o), 72'(2'b01));
        chk("tie2_we", 72'(m_wb_we_o), 72'(0));
        chk("tie2_dat", 72'(m_wb_dat_o), 72'(0));
        next_cycle(); m_wb_ack_i = 1'b0; tx_req(1'b0);            // cycle 5
        next_cycle(); tx_req(1'b1); rx_req(1'b1);                 // cycle 6
        next_cycle(); m_wb_ack_i = 1'b1;                          // cycle 7
        mid(); chk("tie3_grant", 72'(grant_o), 72'(2'b10));
        next_cycle(); m_wb_ack_i = 1'b0; tx_req(1'b0); rx_req(1'b0); // cycle 8
        next_cycle();

        // RX requests while TX holds the bus.
        reset_dut();
        next_cycle(); tx_req(1'b1);                               // cycle 0
        next_cycle();                                             // cycle 1
        next_cycle(); rx_req(1'b1); m_wb_ack_i = 1'b1;            // cycle 2
        mid(); chk("hold_rxack", 72'(rx_ack_o), 72'(0));
        chk("hold_txack", 72'(tx_ack_o), 72'(1));
        next_cycle(); m_wb_ack_i = 1'b0; tx_req(1'b0);            // cycle 3
        next_cycle();                                             // cycle 4
        mid(); chk("hold_idle", 72'(grant_o), 72'(0));
        next_cycle(); m_wb_ack_i = 1'b1;                          // cycle 5
        mid(); chk("hold_rx_grant", 72'(grant_o), 72'(2'b10));
        chk("hold_rx_ack", 72'(rx_ack_o), 72'(1));
        next_cycle(); m_wb_ack_i = 1'b0; rx_req(1'b0);            // cycle 6
        next_cycle();

        // Stall timeout (TIMEOUT=4) and late ack in ABORT.
        reset_dut();
        next_cycle(); tx_req(1'b1);                               // cycle 0
        next_cycle();                                             // cycle 1
        next_cycle();                                             // cycle 2
        next_cycle();                                             // cycle 3
        mid(); chk("to_c3_err", 72'(tx_err_o), 72'(0));
        next_cycle();                                             // cycle 4
        mid(); chk("to_c4_err", 72'(tx_err_o), 72'(1));
        chk("to_c4_rxerr", 72'(rx_err_o), 72'(0));
        chk("to_c4_cyc", 72'(m_wb_cyc_o), 72'(1));
        next_cycle();                                             // cycle 5
        mid(); chk("to_c5_err", 72'(tx_err_o), 72'(0));
        chk("to_c5_cyc", 72'(m_wb_cyc_o), 72'(0));
        chk("to_c5_busy", 72'(busy_o), 72'(1));
        next_cycle(); m_wb_ack_i = 1'b1;                          // cycle 6
        mid(); chk("abort_late_ack", 72'({tx_ack_o, rx_ack_o}), 72'(0));
        next_cycle(); m_wb_ack_i = 1'b0;                          // cycle 7
        mid(); chk("abort_hold", 72'(busy_o), 72'(1));
        next_cycle(); tx_req(1'b0);                               // cycle 8
        next_cycle();                                             // cycle 9
        mid(); chk("abort_release", 72'(busy_o), 72'(0));

        // Asynchronous reset during an RX grant.
        reset_dut();
        next_cycle(); rx_req(1'b1);                               // cycle 0
        next_cycle();                                             // cycle 1
        mid(); chk("arst_pre_grant", 72'(grant_o), 72'(2'b10));
        #2; m_wb_ack_i = 1'b1; rst = 1'b1;
        #1; chk("arst_cyc", 72'(m_wb_cyc_o), 72'(0));
        chk("arst_rxack", 72'(rx_ack_o), 72'(0));
        chk("arst_grant", 72'(grant_o), 72'(0));
        @(posedge clk); #3;
        rst = 1'b0; m_wb_ack_i = 1'b0; tx_req(1'b1);              // cycle 2
        next_cycle(); m_wb_ack_i = 1'b1;                          // cycle 3
        mid(); chk("arst_tie_rx", 72'(grant_o), 72'(2'b10));
        next_cycle(); m_wb_ack_i = 1'b0; tx_req(1'b0); rx_req(1'b0);
        next_cycle();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
